// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
// chan_idx_w gives the cfg_chan width, which is never narrower than one bit.
package clkdiv_pkg;

    localparam int CHANNELS_DEF    = 4;
    localparam int WIDTH_DEF       = 32;
    localparam int DEFAULT_DIV_DEF = 50_000_000;

    function automatic int chan_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, active and pending divisor,
// the 50% output clock and a tick strobe on every output toggle.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] div_reg, div_next;
    logic [WIDTH-1:0] pend_div_reg, pend_div_next;
    logic             pend_reg, pend_next;
    logic             clk_reg, clk_next;
    logic             tick_reg, tick_next;
    logic [WIDTH-1:0] load_div;
    logic             terminal;

    // A divisor of zero would never reach terminal count, so it becomes 1.
    assign load_div = (wr_div == '0) ? WIDTH'(1) : wr_div;
    assign terminal = (count_reg == div_reg - WIDTH'(1));

    always_comb begin
        count_next    = count_reg;
        div_next      = div_reg;
        pend_div_next = pend_div_reg;
        pend_next     = pend_reg;
        clk_next      = clk_reg;
        tick_next     = 1'b0;
        if (sync || !en) begin
            // Stopped or restarting: a pending divisor has nothing to wait for.
            if (pend_reg) begin
                div_next  = pend_div_reg;
                pend_next = 1'b0;
            end
            if (sync) begin
                count_next = '0;
                clk_next   = 1'b0;
            end
            if (wr) begin
                div_next   = load_div;
                count_next = '0;
            end
        end else begin
            if (terminal) begin
                count_next = '0;
                clk_next   = ~clk_reg;
                tick_next  = 1'b1;
                if (pend_reg) begin
                    div_next  = pend_div_reg;
                    pend_next = 1'b0;
                end
            end else begin
                count_next = count_reg + WIDTH'(1);
            end
            // Held back until the next half-period boundary.
            if (wr) begin
                pend_div_next = load_div;
                pend_next     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= '0;
            div_reg      <= WIDTH'(DEFAULT_DIV);
            pend_div_reg <= '0;
            pend_reg     <= 1'b0;
            clk_reg      <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            count_reg    <= count_next;
            div_reg      <= div_next;
            pend_div_reg <= pend_div_next;
            pend_reg     <= pend_next;
            clk_reg      <= clk_next;
            tick_reg     <= tick_next;
        end
    end

    assign pend    = pend_reg;
    assign clk_out = clk_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: decodes the config port,
// muxes cfg_ready from the addressed channel and fans sync out to all.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS    = CHANNELS_DEF,
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHANNELS-1:0]               en,
    input  logic                              sync,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [chan_idx_w(CHANNELS)-1:0]   cfg_chan,
    input  logic [WIDTH-1:0]                  cfg_div,
    output logic [CHANNELS-1:0]               clk_out,
    output logic [CHANNELS-1:0]               tick
);

    localparam int CIW = chan_idx_w(CHANNELS);

    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] wr;

    // Indices past the last channel stay ready so such writes drain harmlessly.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CIW'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign wr[gi] = cfg_valid && cfg_ready && (cfg_chan == CIW'(gi));

            clkdiv_channel #(
                .WIDTH       (WIDTH),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .en      (en[gi]),
                .sync    (sync),
                .wr      (wr[gi]),
                .wr_div  (cfg_div),
                .pend    (pend[gi]),
                .clk_out (clk_out[gi]),
                .tick    (tick[gi])
            );
        end
    endgenerate

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Multi-channel programmable clock divider and tick generator, the parametrised successor to the team's fixed single-output divider. Each of CHANNELS channels derives a 50%-duty divided clock and a one-cycle tick strobe from clk. Each channel's divisor is runtime-writable through a valid/ready config port. A global sync input phase-aligns all channels. The block sits at the top level and feeds display refresh, debouncers and slow FSMs.

## Interface
- CHANNELS, 4: number of independent divider channels (1–16)
- WIDTH, 32: divisor/counter width
- DEFAULT_DIV, 50000000: divisor loaded into every channel at reset (half-period in clk cycles)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  CHANNELS  per-channel run enable; low freezes that channel's counter and clk_out
- sync  in  1  synchronous restart of all channels
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write can be accepted
- cfg_chan  in  max(1,$clog2(CHANNELS))  target channel
- cfg_div  in  WIDTH  new half-period divisor
- clk_out  out  CHANNELS  divided clocks, period 2·div cycles
- tick  out  CHANNELS  one-cycle strobe coincident with every clk_out toggle

## Operation
- Per channel state: count[WIDTH], div[WIDTH] (active), pend_div[WIDTH], pend_v, clk_out, tick.
- Reset: count=0, div=DEFAULT_DIV, pend_v=0, clk_out=0, tick=0. cfg_ready is combinational, so it is 1 during reset.
- Enabled channel, count==div-1: count←0, clk_out←~clk_out, tick←1. Otherwise count←count+1 and tick←0.
- Disabled channel: count, clk_out and div hold. tick←0.
- Divisor clamp: a cfg_div of 0 is stored as 1. The div=1 case toggles every cycle and holds tick continuously high.
- cfg_ready = ~pend_v[cfg_chan]. A write is accepted when cfg_valid && cfg_ready. A cfg_chan ≥ CHANNELS is accepted and ignored.
- Accepted write, target disabled: div←cfg_div and count←0 on the next edge. clk_out is unchanged. pend_v stays 0.
- Accepted write, target enabled: pend_div←cfg_div, pend_v←1.
- Pending commit: at the next terminal-count edge of that channel, div←pend_div and pend_v←0. The next half-period uses the new div. A write accepted in the same cycle as a terminal count commits at the following terminal count.
- Disabling a channel with pend_v=1 commits pend_div immediately on the next edge.
- sync: on the next edge, all channels go to count=0, clk_out=0, tick=0, and any pending divisors commit. sync overrides terminal count: no toggle and no tick in that cycle. sync and a config write in the same cycle: sync applies first, then the write lands as if the channel were disabled (direct load).
- Arithmetic: count compared against div-1 in WIDTH bits, unsigned. No wrap beyond div-1.

## Timing
- All outputs registered except cfg_ready.
- After rst deassert with en=1: clk_out rises on the DEFAULT_DIV-th rising edge. tick is high for exactly that cycle.
- Steady state: clk_out edges every div cycles. tick is high 1 cycle per edge, i.e. 2 ticks per clk_out period.
- Config-to-effect latency on an enabled channel is at most div + div_new cycles.
- rst asserted mid-period: outputs clear asynchronously and pending writes are lost.

## Structure
- Package clkdiv_pkg: DEFAULT_DIV, WIDTH, CHANNELS defaults, and the chan_idx width function.
- Sub-module clkdiv_channel holds one channel's counter, active/pending divisor, toggle and tick. It is instantiated CHANNELS times by generate.
- The top level does cfg_chan decode, cfg_ready mux and sync fan-out.

## Test plan
- Reset, DEFAULT_DIV=4, en=all 1 → clk_out[0] rises at edge 4, falls at edge 8. tick high at cycles 4 and 8 only.
- Write chan1 div=2 while enabled mid-period → cfg_ready[chan1] low until the next terminal. Afterwards, edges every 2 cycles.
- Second write to the same channel while pend_v=1 → cfg_ready=0 and the write is stalled. A write to chan2 in that cycle is accepted.
- cfg_div=0 on a disabled channel, then enable → clk_out toggles every cycle and tick stays high.
- sync asserted on a cycle where chan0 hits terminal count → no tick, all clk_out=0, all counts=0. Channels are phase-aligned afterwards.
- rst pulse while pend_v=1 → clk_out=0, div=DEFAULT_DIV, and pending cleared.
